// File: rtl/usbf_cdc_pkg.sv
// usbf_cdc_pkg: shared constants for the USB function clock-domain-crossing synchronisers.
package usbf_cdc_pkg;
   localparam int USBF_CDC_STAGES_DEF = 2;
   localparam int USBF_CDC_STAGES_MIN = 2;
   localparam int USBF_CDC_STAGES_MAX = 4;
   localparam int USBF_CDC_FCNT_W     = 4;
endpackage

// File: rtl/usbf_cdc_chain.sv
// usbf_cdc_chain: W-bit, STAGES-deep synchroniser flop chain, asynchronously cleared to 0.
module usbf_cdc_chain
   import usbf_cdc_pkg::*;
#(
   parameter int W      = 1,
   parameter int STAGES = USBF_CDC_STAGES_DEF
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [STAGES-1:0][W-1:0] r;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) r <= '0;
      else       r <= {r[STAGES-2:0], d};
   assign q = r[STAGES-1];
endmodule

// File: rtl/usbf_cdc_rx_bank.sv
// usbf_cdc_rx_bank: destination-side synchroniser bank (toggle events, levels, qualified bus, line-state filter).
// Optional glitch filter on the line-state channel is enabled by defining USBF_CDC_FILT_EN.
module usbf_cdc_rx_bank
   import usbf_cdc_pkg::*;
#(
   parameter int STAGES   = USBF_CDC_STAGES_DEF,
   parameter int N_TGL    = 4,
   parameter int N_LVL    = 8,
   parameter int BUS_W    = 16,
   parameter int FILT_W   = 2,
   parameter int FILT_CNT = 4
) (
   input  logic              hclk_i,
   input  logic              rstn_i,
   input  logic [N_TGL-1:0]  tgl_i,
   output logic [N_TGL-1:0]  pulse_o,
   input  logic [N_LVL-1:0]  lvl_i,
   output logic [N_LVL-1:0]  lvl_o,
   input  logic [BUS_W-1:0]  bus_i,
   input  logic              bus_tgl_i,
   output logic [BUS_W-1:0]  bus_o,
   output logic              bus_vld_o,
   input  logic [FILT_W-1:0] filt_i,
   output logic [FILT_W-1:0] filt_o,
   output logic              filt_chg_o
);
   if (STAGES < USBF_CDC_STAGES_MIN || STAGES > USBF_CDC_STAGES_MAX) begin : g_bad_stages
      $error("usbf_cdc_rx_bank: STAGES out of range");
   end
   if (FILT_CNT < 1 || FILT_CNT > 15) begin : g_bad_filt_cnt
      $error("usbf_cdc_rx_bank: FILT_CNT out of range");
   end

   localparam logic [2:0] WARM_END = 3'(STAGES + 1);

   logic [N_TGL-1:0]  t_sync, t_ref;
   logic              b_sync, b_ref;
   logic [FILT_W-1:0] f_sync;
   logic [2:0]        wcnt;
   logic              warm;

   usbf_cdc_chain #(.W(N_TGL),  .STAGES(STAGES)) u_tgl  (.clk(hclk_i), .rstn(rstn_i), .d(tgl_i),     .q(t_sync));
   usbf_cdc_chain #(.W(N_LVL),  .STAGES(STAGES)) u_lvl  (.clk(hclk_i), .rstn(rstn_i), .d(lvl_i),     .q(lvl_o));
   usbf_cdc_chain #(.W(1),      .STAGES(STAGES)) u_btgl (.clk(hclk_i), .rstn(rstn_i), .d(bus_tgl_i), .q(b_sync));
   usbf_cdc_chain #(.W(FILT_W), .STAGES(STAGES)) u_filt (.clk(hclk_i), .rstn(rstn_i), .d(filt_i),    .q(f_sync));

   // References keep tracking during warm-up so levels present at reset release never look like events
   assign warm = wcnt != WARM_END;

   always_ff @(posedge hclk_i or negedge rstn_i)
      if (!rstn_i) wcnt <= '0;
      else if (warm) wcnt <= wcnt + 3'd1;

   always_ff @(posedge hclk_i or negedge rstn_i)
      if (!rstn_i) begin
         t_ref   <= '0;
         pulse_o <= '0;
      end else begin
         t_ref   <= t_sync;
         pulse_o <= warm ? '0 : t_sync ^ t_ref;
      end

   // bus_i is only sampled once the synchronised toggle shows it has been stable for STAGES cycles
   always_ff @(posedge hclk_i or negedge rstn_i)
      if (!rstn_i) begin
         b_ref     <= 1'b0;
         bus_o     <= '0;
         bus_vld_o <= 1'b0;
      end else begin
         b_ref     <= b_sync;
         bus_vld_o <= !warm && (b_sync != b_ref);
         if (!warm && (b_sync != b_ref)) bus_o <= bus_i;
      end

`ifdef USBF_CDC_FILT_EN
   localparam logic [USBF_CDC_FCNT_W-1:0] FCNT = USBF_CDC_FCNT_W'(FILT_CNT);

   logic [FILT_W-1:0]          f_prev;
   logic [USBF_CDC_FCNT_W-1:0] f_cnt;

   // A new value must hold FILT_CNT consecutive cycles before it is accepted
   always_ff @(posedge hclk_i or negedge rstn_i)
      if (!rstn_i) begin
         f_prev     <= '0;
         f_cnt      <= '0;
         filt_o     <= '0;
         filt_chg_o <= 1'b0;
      end else begin
         f_prev     <= f_sync;
         filt_chg_o <= 1'b0;
         if (warm) begin
            filt_o <= f_sync;
            f_cnt  <= '0;
         end else if (f_sync != f_prev || f_sync == filt_o) begin
            f_cnt <= '0;
         end else if (f_cnt + 1'b1 == FCNT) begin
            filt_o     <= f_sync;
            f_cnt      <= '0;
            filt_chg_o <= 1'b1;
         end else begin
            f_cnt <= f_cnt + 1'b1;
         end
      end
`else
   always_ff @(posedge hclk_i or negedge rstn_i)
      if (!rstn_i) begin
         filt_o     <= '0;
         filt_chg_o <= 1'b0;
      end else begin
         filt_o     <= f_sync;
         filt_chg_o <= !warm && (f_sync != filt_o);
      end
`endif
endmodule

// File: tb/tb_usbf_cdc_rx_bank.sv
// tb_usbf_cdc_rx_bank: directed self-checking bench for usbf_cdc_rx_bank at default parameters.
module tb_usbf_cdc_rx_bank;
`ifdef USBF_CDC_FILT_EN
   localparam int FLAT = 4;
`else
   localparam int FLAT = 0;
`endif

   logic        hclk_i = 1'b0;
   logic        rstn_i;
   logic [3:0]  tgl_i;
   logic [3:0]  pulse_o;
   logic [7:0]  lvl_i;
   logic [7:0]  lvl_o;
   logic [15:0] bus_i;
   logic        bus_tgl_i;
   logic [15:0] bus_o;
   logic        bus_vld_o;
   logic [1:0]  filt_i;
   logic [1:0]  filt_o;
   logic        filt_chg_o;

   int n_chk = 0;
   int n_fail = 0;

   usbf_cdc_rx_bank dut (
      .hclk_i(hclk_i), .rstn_i(rstn_i),
      .tgl_i(tgl_i), .pulse_o(pulse_o),
      .lvl_i(lvl_i), .lvl_o(lvl_o),
      .bus_i(bus_i), .bus_tgl_i(bus_tgl_i), .bus_o(bus_o), .bus_vld_o(bus_vld_o),
      .filt_i(filt_i), .filt_o(filt_o), .filt_chg_o(filt_chg_o)
   );

   always #5 hclk_i = ~hclk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge hclk_i);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pulse"}, 32'(pulse_o), 0);
      check({tag, "_lvl"}, 32'(lvl_o), 0);
      check({tag, "_bus"}, 32'(bus_o), 0);
      check({tag, "_vld"}, 32'(bus_vld_o), 0);
      check({tag, "_filt"}, 32'(filt_o), 0);
      check({tag, "_chg"}, 32'(filt_chg_o), 0);
   endtask

   initial begin
      rstn_i = 1'b0; tgl_i = 4'hF; lvl_i = 8'hA5;
      bus_i = 16'h0; bus_tgl_i = 1'b0; filt_i = 2'b00;
      step(3);
      check_all_zero("reset");
      rstn_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("warm_pulse", 32'(pulse_o), 0);
         if (i == 1) check("lvl_early", 32'(lvl_o), 0);
         if (i == 2) check("lvl_a5", 32'(lvl_o), 32'hA5);
      end
      // single-channel toggle 1 -> 0 on bit 1, then back
      tgl_i = 4'hD;
      for (int j = 1; j <= 4; j++) begin
         step();
         check("tgl1_fall", 32'(pulse_o), j == 3 ? 32'h2 : 32'h0);
      end
      step(6);
      tgl_i = 4'hF;
      for (int j = 1; j <= 4; j++) begin
         step();
         check("tgl1_rise", 32'(pulse_o), j == 3 ? 32'h2 : 32'h0);
      end
      tgl_i = 4'hA;
      for (int j = 1; j <= 4; j++) begin
         step();
         check("tgl_multi", 32'(pulse_o), j == 3 ? 32'h5 : 32'h0);
      end
      lvl_i = 8'h3C;
      step();
      check("lvl_hold", 32'(lvl_o), 32'hA5);
      step();
      check("lvl_3c", 32'(lvl_o), 32'h3C);
      // qualified bus capture
      bus_i = 16'h1234; bus_tgl_i = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         step();
         check("bus_vld", 32'(bus_vld_o), j == 3 ? 32'h1 : 32'h0);
         check("bus_val", 32'(bus_o), j >= 3 ? 32'h1234 : 32'h0);
      end
      bus_i = 16'hBEEF;
      step(5);
      check("bus_noupd", 32'(bus_o), 32'h1234);
      check("bus_novld", 32'(bus_vld_o), 0);
      bus_i = 16'h5A5A; bus_tgl_i = 1'b0;
      step(3);
      check("bus2_vld", 32'(bus_vld_o), 1);
      check("bus2_val", 32'(bus_o), 32'h5A5A);
      step();
      check("bus2_vld_off", 32'(bus_vld_o), 0);
      // line-state step 00 -> 11
      filt_i = 2'b11;
      for (int j = 1; j <= FLAT + 4; j++) begin
         step();
         check("filt_val", 32'(filt_o), j >= FLAT + 3 ? 32'h3 : 32'h0);
         check("filt_chg", 32'(filt_chg_o), j == FLAT + 3 ? 32'h1 : 32'h0);
      end
      // reset in the middle of a bus transfer
      bus_i = 16'h1111; bus_tgl_i = 1'b1;
      step();
      rstn_i = 1'b0;
      #1;
      check_all_zero("midrst");
      step(2);
      rstn_i = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         step();
         check("post_rst_vld", 32'(bus_vld_o), 0);
         check("post_rst_pulse", 32'(pulse_o), 0);
      end
      check("post_rst_bus", 32'(bus_o), 0);
      bus_i = 16'h7777; bus_tgl_i = 1'b0;
      step(3);
      check("resume_vld", 32'(bus_vld_o), 1);
      check("resume_val", 32'(bus_o), 32'h7777);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
